// File: rtl/booth_multiplier.sv
// Multi-cycle signed Booth multiplier producing a 2*WIDTH product as hi/lo via a start/busy/done handshake.
// Optional BOOTH_RADIX4_EN selects bit-pair (radix-4) recoding, halving the number of RUN steps.
module booth_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

`ifdef BOOTH_RADIX4_EN
    localparam int unsigned AW    = WIDTH + 2;
    localparam int unsigned STEPS = WIDTH / 2;
`else
    localparam int unsigned AW    = WIDTH + 1;
    localparam int unsigned STEPS = WIDTH;
`endif
    localparam int unsigned CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [AW-1:0]    acc, acc_next;
    logic             q_m1, q_m1_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             busy_next, done_next;

    logic [AW-1:0]    m_ext;
    logic [AW-1:0]    sum;
    logic [AW-1:0]    acc_sh;
    logic [WIDTH-1:0] q_sh;
    logic             q_m1_sh;

    assign m_ext = {{(AW - WIDTH){m_reg[WIDTH-1]}}, m_reg};

    // Booth recoding of the low multiplier bits, then the arithmetic shift of {A,Q,q(-1)}
    always_comb begin
        sum     = acc;
        acc_sh  = '0;
        q_sh    = '0;
        q_m1_sh = 1'b0;
`ifdef BOOTH_RADIX4_EN
        case ({q_reg[1:0], q_m1})
            3'b001, 3'b010: sum = acc + m_ext;
            3'b011:         sum = acc + (m_ext << 1);
            3'b100:         sum = acc - (m_ext << 1);
            3'b101, 3'b110: sum = acc - m_ext;
            default:        sum = acc;
        endcase
        acc_sh  = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_sh    = {sum[1:0], q_reg[WIDTH-1:2]};
        q_m1_sh = q_reg[1];
`else
        case ({q_reg[0], q_m1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
        acc_sh  = {sum[AW-1], sum[AW-1:1]};
        q_sh    = {sum[0], q_reg[WIDTH-1:1]};
        q_m1_sh = q_reg[0];
`endif
    end

    // Next-state and next-register values
    always_comb begin
        state_next = state;
        m_next     = m_reg;
        q_next     = q_reg;
        acc_next   = acc;
        q_m1_next  = q_m1;
        count_next = count;
        hi_next    = hi;
        lo_next    = lo;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    m_next     = M;
                    q_next     = Q;
                    acc_next   = '0;
                    q_m1_next  = 1'b0;
                    count_next = '0;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == CW'(STEPS)) begin
                    hi_next    = acc[WIDTH-1:0];
                    lo_next    = q_reg;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    acc_next   = acc_sh;
                    q_next     = q_sh;
                    q_m1_next  = q_m1_sh;
                    count_next = count + CW'(1);
                    busy_next  = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            m_reg <= '0;
            q_reg <= '0;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            m_reg <= m_next;
            q_reg <= q_next;
            acc   <= acc_next;
            q_m1  <= q_m1_next;
            count <= count_next;
            hi    <= hi_next;
            lo    <= lo_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: vector table, handshake corner cases and random products.
module tb_booth_multiplier;

`ifdef BOOTH_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif
    localparam int LIMIT = 100;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] M;
    logic [31:0] Q;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int total;
    int passed;

    booth_multiplier #(.WIDTH(32)) dut (
        .clock(clock),
        .clear(clear),
        .start(start),
        .M(M),
        .Q(Q),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] p;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One operation; poke_at >= 0 re-asserts start with M=Q=1 that many edges after acceptance
    task automatic run_op(input logic [31:0] m, input logic [31:0] q, input int poke_at,
                          output logic [63:0] prod, output int lat,
                          output bit busy_ok, output bit pulse_ok);
        @(negedge clock);
        M = m; Q = q; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        M = ~m; Q = ~q;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < LIMIT) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clock);
            #1 lat++;
            if (lat == poke_at) begin
                M = 32'd1; Q = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        if (busy) busy_ok = 1'b0;
        prod = {hi, lo};
        @(posedge clock);
        #1 pulse_ok = !done && !busy;
    endtask

    vec_t        vecs[10];
    logic [63:0] prod;
    int          lat;
    bit          busy_ok;
    bit          pulse_ok;

    initial begin
        total = 0; passed = 0;
        clear = 1'b1; start = 1'b0; M = '0; Q = '0;

        vecs[0] = '{32'd6,        32'd7,        64'h0000_0000_0000_002A};
        vecs[1] = '{32'hFFFFFFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{32'h80000000, 32'h80000000, 64'h4000_0000_0000_0000};
        vecs[3] = '{32'h80000000, 32'h7FFFFFFF, 64'hC000_0000_8000_0000};
        vecs[4] = '{32'd0,        32'h12345678, 64'h0000_0000_0000_0000};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000_0000_0000_0001};
        vecs[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[7] = '{32'hFFFFFFFF, 32'h80000000, 64'h0000_0000_8000_0000};
        vecs[8] = '{32'h0000FFFF, 32'h0000FFFF, 64'h0000_0000_FFFE_0001};
        vecs[9] = '{32'hFFFFFFFE, 32'h7FFFFFFF, 64'hFFFF_FFFF_0000_0002};

        repeat (2) @(posedge clock);
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(negedge clock) clear = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].m, vecs[i].q, -1, prod, lat, busy_ok, pulse_ok);
            check($sformatf("vec%0d_product", i), prod, vecs[i].p);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("vec%0d_busy", i), 64'(busy_ok), 64'd1);
            check($sformatf("vec%0d_pulse", i), 64'(pulse_ok), 64'd1);
        end

        // start re-pulsed mid-operation is ignored
        run_op(32'd6, 32'd7, 10, prod, lat, busy_ok, pulse_ok);
        check("ignore_product", prod, 64'h2A);
        check("ignore_latency", 64'(lat), 64'(LAT));
        check("ignore_busy", 64'(busy_ok), 64'd1);
        check("ignore_pulse", 64'(pulse_ok), 64'd1);

        // start held high: ignored in DONE, accepted in the following IDLE cycle
        begin
            int e, e1, e2;
            e = 0; e1 = -1; e2 = -1;
            @(negedge clock);
            M = 32'd6; Q = 32'd7; start = 1'b1;
            @(posedge clock);
            while (e2 < 0 && e < 3 * LIMIT) begin
                @(posedge clock);
                #1 e++;
                if (done) begin
                    if (e1 < 0) e1 = e;
                    else e2 = e;
                end
            end
            start = 1'b0;
            check("held_first", 64'(e1), 64'(LAT));
            check("held_interval", 64'(e2 - e1), 64'(LAT + 2));
            check("held_product", {hi, lo}, 64'h2A);
            repeat (2) @(posedge clock);
        end

        // clear mid-RUN aborts immediately, then a fresh operation runs normally
        @(negedge clock);
        M = 32'd6; Q = 32'd7; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(posedge clock);
        #1 check("abort_busy_before", 64'(busy), 64'd1);
        #3 clear = 1'b1;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clock) clear = 1'b0;
        run_op(32'd2, 32'd3, -1, prod, lat, busy_ok, pulse_ok);
        check("after_clear_product", prod, 64'd6);
        check("after_clear_latency", 64'(lat), 64'(LAT));

        // random signed operands
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] rm, rq;
            logic signed [63:0] a, b, r;
            rm = $urandom();
            rq = $urandom();
            a = {{32{rm[31]}}, rm};
            b = {{32{rq[31]}}, rq};
            r = a * b;
            run_op(rm, rq, -1, prod, lat, busy_ok, pulse_ok);
            check($sformatf("rand%0d_product", i), prod, r);
            check($sformatf("rand%0d_pulse", i), 64'(pulse_ok && lat == LAT), 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
